i2c_scl_timing_unit: RTL and testbench
======================================

Name: i2c_scl_timing_unit

Overview:
- Generates the standard-mode (100 kHz) I2C SCL drive waveform from the fabric clock.
- Provides a glitch-filtered copy of the SCL line read back from the IO buffer, plus single-cycle edge pulses derived from that filtered copy.
- Sits between the I2C master FSM and the SCL tri-state buffer.
- The FSM holds the unit in reset while SCL must stay high, and releases reset to start clocking.

Parameters:
- CLK_FREQ_HZ, 100_000_000: fabric clock frequency.
- SCL_FREQ_HZ, 100_000: generated SCL frequency.
- STAGES, 2: glitch-filter depth in clock cycles; legal range 1..8.
- Derived constant HALF_CNT = CLK_FREQ_HZ/(2*SCL_FREQ_HZ); default 500. Elaboration error if HALF_CNT < 2.

Ports:
- CLK  in  1  fabric clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; synchronous deassertion is the caller's responsibility.
- scl_o  in  1  SCL pad value from the IOBUF O pin; asynchronous to CLK.
- scl_i  out  1  generated SCL drive level to the IOBUF I pin.
- scl_read  out  1  filtered SCL line level.
- scl_read_rise  out  1  one-cycle pulse when scl_read goes 0->1.
- scl_read_fall  out  1  one-cycle pulse when scl_read goes 1->0.

Behaviour:
Reset values (rst=0, immediate, asynchronous):
- scl_i=1, half-period counter=0.
- All filter stages=1, scl_read=1.
- scl_read_rise=0, scl_read_fall=0.

Generator:
- Counter runs 0..HALF_CNT-1 every cycle after rst=1.
- On the cycle the counter equals HALF_CNT-1, it wraps to 0 and scl_i toggles. scl_i is a register output with no combinational path.
- The first scl_i falling edge occurs exactly HALF_CNT rising CLK edges after rst deasserts, so SCL stays high for a full half period after release. This gives the START hold time.
- Duty cycle is exactly 50%; period is 2*HALF_CNT cycles, i.e. 1000 at default.
- Reset asserted mid-period: scl_i returns to 1 immediately and the counter clears. The next release restarts the timing from the beginning with no residual phase.

Filter:
- A STAGES-bit shift register samples scl_o each cycle; it doubles as the metastability synchronizer, and bit 0 is the newest sample.
- scl_read register: set to 1 when all stages are 1, cleared to 0 when all stages are 0, otherwise holds.
- Latency: a clean step on scl_o appears on scl_read STAGES+1 rising edges later, i.e. 3 at default.
- Any pulse on scl_o lasting fewer than STAGES consecutive samples never reaches scl_read.

Edge pulses:
- Registered comparison of scl_read against its previous value.
- Each pulse is asserted the cycle after scl_read changes, for exactly 1 cycle.
- Rise and fall can never be asserted together.
- No pulses are generated by reset assertion or by reset release.

Counter width is $clog2(HALF_CNT); no other arithmetic is performed.

Decomposition:
- Package i2c_timing_pkg holds CLK_FREQ_HZ/SCL_FREQ_HZ defaults, the HALF_CNT computation function, and the I2C bus idle level constant (1).
- One sub-module, scl_glitch_filter, is natural. It is parameterised by STAGES, has ports CLK, rst, din, dout, and carries the same reset rules.
- The generator and the edge detector stay in the top module.

Test Plan:
1. Reset and start: hold rst=0 for 20 cycles (scl_i=1, scl_read=1, both pulses 0); release -> scl_i stays 1 for exactly 500 cycles, then falls and toggles every 500 cycles; measure 3 full 1000-cycle periods.
2. Reset mid-period: assert rst=0 at counter=250 while scl_i=0 -> scl_i=1 the same cycle; release -> next fall exactly 500 cycles later.
3. Filter step: with scl_o=1 stable, drive scl_o=0 -> scl_read=0 on the 3rd edge; scl_read_fall=1 for one cycle on the 4th edge; rising step gives the mirror result.
4. Glitch rejection: with scl_o=1, drive a 1-cycle 0 pulse -> scl_read stays 1 and no fall pulse; a 2-cycle 0 pulse -> scl_read goes 0 (STAGES=2).
5. Loopback: tie scl_o=scl_i -> scl_read follows scl_i delayed 3 cycles; rise and fall pulses alternate with 500-cycle spacing and never coincide.
6. Parameter sweep: STAGES=1 and STAGES=4 with HALF_CNT=4 (CLK_FREQ_HZ=800_000) -> filter latency STAGES+1, SCL period 8 cycles.

Source files
------------

// File: rtl/i2c_timing_pkg.sv
// Shared constants for the I2C SCL timing unit: default clock rates,
// half-period computation and the bus idle level.
package i2c_timing_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 100_000_000;
  localparam int unsigned SCL_FREQ_HZ_DEFAULT = 100_000;
  localparam logic        I2C_IDLE_LEVEL      = 1'b1;

  function automatic int unsigned calc_half_cnt(input int unsigned clk_hz,
                                                input int unsigned scl_hz);
    return clk_hz / (2 * scl_hz);
  endfunction

endpackage

// File: rtl/scl_glitch_filter.sv
// Glitch filter / synchronizer for the SCL readback: output changes only after
// STAGES consecutive identical samples of din.
module scl_glitch_filter
  import i2c_timing_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] shreg;

  // NOTE: the sample chain is reset to the idle level so that releasing reset
  // never looks like a falling edge on a bus that is already high.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of its neighbours, which is what makes this a shift.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      shreg <= {STAGES{I2C_IDLE_LEVEL}};
      dout  <= I2C_IDLE_LEVEL;
    end else begin
      shreg <= STAGES'({shreg, din});
      if (&shreg) begin
        dout <= 1'b1;
      end else if (~|shreg) begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_scl_timing_unit.sv
// Standard-mode SCL generator with filtered readback and edge pulses.
// Held in reset by the master FSM while SCL must idle high.
module i2c_scl_timing_unit
  import i2c_timing_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned SCL_FREQ_HZ = SCL_FREQ_HZ_DEFAULT,
  parameter int          STAGES      = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic scl_o,
  output logic scl_i,
  output logic scl_read,
  output logic scl_read_rise,
  output logic scl_read_fall
);

  localparam int unsigned HALF_CNT = calc_half_cnt(CLK_FREQ_HZ, SCL_FREQ_HZ);
  localparam int          CNT_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CNT - 1);

  if (HALF_CNT < 2) begin : g_half_cnt_check
    $error("i2c_scl_timing_unit: HALF_CNT must be at least 2");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_stages_check
    $error("i2c_scl_timing_unit: STAGES must be in 1..8");
  end

  logic [CNT_W-1:0] half_cnt;
  logic             scl_read_q;

  // Counter starts from zero on release, so SCL idles high for one full
  // half period before the first fall (START hold time).
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      half_cnt <= '0;
      scl_i    <= I2C_IDLE_LEVEL;
    end else if (half_cnt == CNT_LAST) begin
      half_cnt <= '0;
      scl_i    <= ~scl_i;
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

  scl_glitch_filter #(
    .STAGES(STAGES)
  ) u_filter (
    .CLK (CLK),
    .rst (rst),
    .din (scl_o),
    .dout(scl_read)
  );

  // Previous value resets to idle too, so neither reset edge makes a pulse.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      scl_read_q    <= I2C_IDLE_LEVEL;
      scl_read_rise <= 1'b0;
      scl_read_fall <= 1'b0;
    end else begin
      scl_read_q    <= scl_read;
      scl_read_rise <= scl_read & ~scl_read_q;
      scl_read_fall <= ~scl_read & scl_read_q;
    end
  end

endmodule

// File: tb/tb_i2c_scl_timing_unit.sv
// Bench for i2c_scl_timing_unit: default instance plus STAGES=1/4 instances
// at HALF_CNT=4, checked each cycle against a behavioural model.
module tb_i2c_scl_timing_unit;

  localparam int N = 3;
  localparam int HALF [N] = '{500, 4, 4};
  localparam int STG  [N] = '{2, 1, 4};

  logic         clk;
  logic         rst;
  logic         loop;
  logic [N-1:0] drv;
  logic [N-1:0] scl_o, scl_i, rd, rise, fall;
  logic [N-1:0] smp;
  logic         rst_smp;

  int total = 0;
  int bad   = 0;

  assign scl_o = loop ? scl_i : drv;

  i2c_scl_timing_unit dut0 (
    .CLK(clk), .rst(rst), .scl_o(scl_o[0]), .scl_i(scl_i[0]),
    .scl_read(rd[0]), .scl_read_rise(rise[0]), .scl_read_fall(fall[0])
  );

  i2c_scl_timing_unit #(.CLK_FREQ_HZ(800_000), .SCL_FREQ_HZ(100_000), .STAGES(1)) dut1 (
    .CLK(clk), .rst(rst), .scl_o(scl_o[1]), .scl_i(scl_i[1]),
    .scl_read(rd[1]), .scl_read_rise(rise[1]), .scl_read_fall(fall[1])
  );

  i2c_scl_timing_unit #(.CLK_FREQ_HZ(800_000), .SCL_FREQ_HZ(100_000), .STAGES(4)) dut2 (
    .CLK(clk), .rst(rst), .scl_o(scl_o[2]), .scl_i(scl_i[2]),
    .scl_read(rd[2]), .scl_read_rise(rise[2]), .scl_read_fall(fall[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // What each DUT saw at the last rising edge.
  always @(posedge clk) begin
    smp     <= scl_o;
    rst_smp <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: scl_i from edges since release; scl_read is the value of the most
  // recent run of >= STAGES equal samples completed before the edge.
  int          n       [N];
  int          run_len [N];
  logic        run_val [N];
  logic [2:0]  rd_h    [N];
  logic        nr;
  logic        exp_i;

  initial begin
    for (int i = 0; i < N; i++) begin
      n[i] = 0; run_len[i] = STG[i]; run_val[i] = 1'b1; rd_h[i] = 3'b111;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst) begin
          n[i] = 0; run_len[i] = STG[i]; run_val[i] = 1'b1; rd_h[i] = 3'b111;
        end else if (rst_smp) begin
          n[i]++;
          nr = (run_len[i] >= STG[i]) ? run_val[i] : rd_h[i][0];
          if (smp[i] == run_val[i]) begin
            if (run_len[i] < 16) run_len[i]++;
          end else begin
            run_val[i] = smp[i];
            run_len[i] = 1;
          end
          rd_h[i] = {rd_h[i][1:0], nr};
        end
        exp_i = (((n[i] / HALF[i]) % 2) == 0);
        check($sformatf("model scl_i[%0d]", i), scl_i[i], exp_i);
        check($sformatf("model scl_read[%0d]", i), rd[i], rd_h[i][0]);
        check($sformatf("model rise[%0d]", i), rise[i], rd_h[i][1] & ~rd_h[i][2]);
        check($sformatf("model fall[%0d]", i), fall[i], ~rd_h[i][1] & rd_h[i][2]);
        check($sformatf("rise&fall[%0d]", i), rise[i] & fall[i], 0);
      end
    end
  end

  task automatic wait_level(input logic lvl, output int c);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (scl_i[0] !== lvl && c < 3000);
    check("wait scl_i level", scl_i[0], lvl);
  endtask

  int c0, c1;
  int ptime [$];
  logic ptype [$];
  logic [3:0] hist;

  initial begin
    rst = 1'b0; loop = 1'b0; drv = '1;

    // 1. reset and start
    repeat (20) @(posedge clk);
    #1;
    check("reset scl_i", scl_i[0], 1);
    check("reset scl_read", rd[0], 1);
    check("reset rise", rise[0], 0);
    check("reset fall", fall[0], 0);
    rst = 1'b1;
    c0 = 0;
    do begin
      @(posedge clk); #1;
      c0++;
      if (c0 == 3)  check("sweep scl_i @3",  {scl_i[2], scl_i[1]}, 2'b11);
      if (c0 == 4)  check("sweep scl_i @4",  {scl_i[2], scl_i[1]}, 2'b00);
      if (c0 == 8)  check("sweep scl_i @8",  {scl_i[2], scl_i[1]}, 2'b11);
      if (c0 == 12) check("sweep scl_i @12", {scl_i[2], scl_i[1]}, 2'b00);
    end while (scl_i[0] !== 1'b0 && c0 < 3000);
    check("first fall delay", c0, 500);
    for (int p = 0; p < 3; p++) begin
      wait_level(1'b1, c0);
      wait_level(1'b0, c1);
      check("high half", c0, 500);
      check("period", c0 + c1, 1000);
    end

    // 2. reset mid-period (counter = 250, scl_i low)
    repeat (250) @(posedge clk);
    #1;
    check("low before reset", scl_i[0], 0);
    rst = 1'b0;
    #1;
    check("async reset scl_i", scl_i[0], 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_level(1'b0, c0);
    check("fall after re-release", c0, 500);

    // 3. filter steps
    repeat (8) @(posedge clk);
    #1;
    drv = '0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("fall step rd0 k%0d", k), rd[0], (k >= 3) ? 0 : 1);
      check($sformatf("fall step pulse0 k%0d", k), fall[0], (k == 4) ? 1 : 0);
      check($sformatf("fall step rd1 k%0d", k), rd[1], (k >= 2) ? 0 : 1);
      check($sformatf("fall step rd2 k%0d", k), rd[2], (k >= 5) ? 0 : 1);
    end
    drv = '1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("rise step rd0 k%0d", k), rd[0], (k >= 3) ? 1 : 0);
      check($sformatf("rise step pulse0 k%0d", k), rise[0], (k == 4) ? 1 : 0);
      check($sformatf("rise step rd1 k%0d", k), rd[1], (k >= 2) ? 1 : 0);
      check($sformatf("rise step rd2 k%0d", k), rd[2], (k >= 5) ? 1 : 0);
    end

    // 4. glitch rejection
    repeat (8) @(posedge clk);
    #1;
    drv = '0;
    @(posedge clk); #1;
    drv = '1;
    for (int k = 2; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("glitch1 rd0 k%0d", k), rd[0], 1);
      check($sformatf("glitch1 fall0 k%0d", k), fall[0], 0);
      check($sformatf("glitch1 rd1 k%0d", k), rd[1], (k == 2) ? 0 : 1);
    end
    repeat (8) @(posedge clk);
    #1;
    drv = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drv = '1;
    for (int k = 3; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("glitch2 rd0 k%0d", k), rd[0], (k == 3 || k == 4) ? 0 : 1);
      check($sformatf("glitch2 rd2 k%0d", k), rd[2], 1);
    end

    // 5. loopback
    loop = 1'b1;
    hist = {4{scl_i[0]}};
    for (int t = 0; t < 2200; t++) begin
      @(posedge clk); #1;
      hist = {hist[2:0], scl_i[0]};
      if (t >= 8) check("loop delay", rd[0], hist[3]);
      if (rise[0] || fall[0]) begin
        ptime.push_back(t);
        ptype.push_back(rise[0]);
      end
    end
    check("loop pulse count >= 4", ptime.size() >= 4, 1);
    for (int j = 2; j < ptime.size(); j++) begin
      check("loop pulse spacing", ptime[j] - ptime[j-1], 500);
      check("loop pulse alternate", ptype[j] != ptype[j-1], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
